// File: rtl/nes_pad_pkg.sv
// Shared types for the NES controller-port poller and the memory mapper's $4016 logic.
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    SETTLE = 3'd2,
    CLK_HI = 3'd3,
    CLK_LO = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Bit positions inside keystates; the pad shifts A out first, so A lands in the MSB.
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nes_pad_poller_sync.sv
// Two-flop synchronizer for the asynchronous pad data line; reset value is selectable.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_poller.sv
// Polls a CD4021-based NES pad over latch/clock/data and presents the 8 button bits.
module nes_pad_poller
  import nes_pad_pkg::*;
#(
  parameter int LATCH_CYC = 600,
  parameter int HALF_CYC  = 300,
  parameter int POLL_CYC  = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] keystates,
  output logic       valid,
  output logic       busy,
  output state_t     state
);

  localparam int PW = $clog2(max2(LATCH_CYC, HALF_CYC));
  localparam int TW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam logic [PW-1:0] LATCH_LAST = PW'(LATCH_CYC - 1);
  localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_CYC - 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_CYC - 1);

  logic          sync_data;
  logic [PW-1:0] phase;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic [7:0]    shreg;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pad_data),
    .q     (sync_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      keystates <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
      phase     <= '0;
      bit_cnt   <= '0;
      timer     <= '0;
      shreg     <= '0;
    end else begin
      valid <= 1'b0;
      // Free-running poll period; it keeps counting through the frame so start-to-start is fixed.
      if (timer != '0) timer <= timer - TW'(1);
      case (state)
        IDLE: begin
          if (timer == '0) begin
            timer     <= TIMER_LOAD;
            state     <= LATCH;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
            phase     <= '0;
            bit_cnt   <= '0;
          end
        end
        LATCH: begin
          if (phase == LATCH_LAST) begin
            phase     <= '0;
            pad_latch <= 1'b0;
            state     <= SETTLE;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        SETTLE: begin
          if (phase == HALF_LAST) begin
            phase   <= '0;
            shreg   <= {shreg[6:0], ~sync_data};
            bit_cnt <= 3'd1;
            pad_clk <= 1'b1;
            state   <= CLK_HI;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        CLK_HI: begin
          if (phase == HALF_LAST) begin
            phase   <= '0;
            pad_clk <= 1'b0;
            state   <= CLK_LO;
          end else begin
            phase <= phase + PW'(1);
          end
        end
        CLK_LO: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            shreg <= {shreg[6:0], ~sync_data};
            // bit_cnt holds bits already captured; 7 means this shift is the eighth.
            if (bit_cnt == 3'd7) begin
              state <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              pad_clk <= 1'b1;
              state   <= CLK_HI;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        DONE: begin
          keystates <= shreg;
          valid     <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_poller.sv
// Bench for nes_pad_poller: CD4021 pad model, frame timing monitor and keystates scoreboard.
module tb_nes_pad_poller;
  import nes_pad_pkg::*;

  localparam int LATCH_CYC = 4;
  localparam int HALF_CYC  = 4;
  localparam int POLL_CYC  = 100;
  localparam int FRAME_LEN = LATCH_CYC + HALF_CYC * 15 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (slow poll) ----------------
  logic       pad_data, pad_latch, pad_clk, valid, busy;
  logic [7:0] keystates;
  state_t     st;

  nes_pad_poller #(.LATCH_CYC(LATCH_CYC), .HALF_CYC(HALF_CYC), .POLL_CYC(POLL_CYC)) u_dut (
    .clk(clk), .reset(reset), .pad_data(pad_data), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .keystates(keystates), .valid(valid), .busy(busy), .state(st)
  );

  // ---------------- DUT (poll period shorter than a frame) ----------------
  logic       pad_data_f = 1'b1;
  logic       pad_latch_f, pad_clk_f, valid_f, busy_f;
  logic [7:0] keystates_f;
  state_t     st_f;

  nes_pad_poller #(.LATCH_CYC(LATCH_CYC), .HALF_CYC(HALF_CYC), .POLL_CYC(10)) u_fast (
    .clk(clk), .reset(reset), .pad_data(pad_data_f), .pad_latch(pad_latch_f), .pad_clk(pad_clk_f),
    .keystates(keystates_f), .valid(valid_f), .busy(busy_f), .state(st_f)
  );

  // ---------------- pad model: CD4021, serial input tied high ----------------
  logic [7:0] buttons = 8'h00;   // 1 = pressed, keystates bit order
  int         mode = 0;          // 0 = pad model, 1 = unplugged (line high), 2 = line held low
  logic [7:0] pad_sr = 8'hFF;
  logic       pad_clk_q = 1'b0;

  always @(posedge clk) begin
    pad_clk_q <= pad_clk;
    if (pad_latch) pad_sr <= ~buttons;
    else if (pad_clk && !pad_clk_q) pad_sr <= {pad_sr[6:0], 1'b1};
  end

  assign pad_data = (mode == 0) ? pad_sr[7] : ((mode == 1) ? 1'b1 : 1'b0);

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int cmp_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_keys();
    case (mode)
      1:       return 8'h00;
      2:       return 8'hFF;
      default: return buttons;
    endcase
  endfunction

  // ---------------- driver / monitor tasks ----------------
  task automatic wait_latch(output int waited);
    waited = 0;
    while (pad_latch !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
  endtask

  // Called on the first negedge of a frame (latch high); runs until the valid pulse.
  task automatic measure_frame(input int idx, input int change_t, input logic [7:0] change_val);
    int t, latch_len, pulses, bad, overlap, hi_run, lo_run, valid_t;
    logic prev_clk, seen_clk, busy_v;
    logic [7:0] keys_v, exp_v;
    t = 0; latch_len = 0; pulses = 0; bad = 0; overlap = 0; hi_run = 0; lo_run = 0;
    valid_t = -1; prev_clk = 1'b0; seen_clk = 1'b0; busy_v = 1'bx; keys_v = 8'hxx;
    exp_q.push_back(model_keys());
    while (valid_t < 0 && t < 200) begin
      if (t == change_t) buttons = change_val;
      if (pad_latch === 1'b1) latch_len++;
      if (pad_latch === 1'b1 && pad_clk === 1'b1) overlap++;
      if (pad_clk === 1'b1) begin
        if (!prev_clk) begin
          pulses++;
          if (seen_clk && lo_run != HALF_CYC) bad++;
          seen_clk = 1'b1;
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (prev_clk) begin
          if (hi_run != HALF_CYC) bad++;
          lo_run = 0;
        end
        lo_run++;
      end
      prev_clk = (pad_clk === 1'b1);
      if (valid === 1'b1) begin
        valid_t = t;
        busy_v  = busy;
        keys_v  = keystates;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    exp_v = exp_q.pop_front();
    check($sformatf("f%0d_keys", idx), 32'(keys_v), 32'(exp_v));
    check($sformatf("f%0d_valid_at", idx), valid_t, FRAME_LEN);
    check($sformatf("f%0d_latch_len", idx), latch_len, LATCH_CYC);
    check($sformatf("f%0d_clk_pulses", idx), pulses, 7);
    check($sformatf("f%0d_clk_widths", idx), bad, 0);
    check($sformatf("f%0d_overlap", idx), overlap, 0);
    check($sformatf("f%0d_busy_at_valid", idx), 32'(busy_v), 0);
    @(negedge clk);
    check($sformatf("f%0d_valid_one_cycle", idx), 32'(valid), 0);
  endtask

  // Waits for the next latch, checks poll period, then measures the frame.
  task automatic next_frame(input int idx, input int prev_start, input int change_t,
                            input logic [7:0] change_val, output int start);
    int waited;
    wait_latch(waited);
    start = cyc;
    if (prev_start >= 0) check($sformatf("f%0d_period", idx), start - prev_start, POLL_CYC);
    measure_frame(idx, change_t, change_val);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start, prev, waited, n, idle;
    int c0;

    buttons = 8'h81;  // A + Right
    mode = 0;
    repeat (3) @(negedge clk);
    check("rst_latch", 32'(pad_latch), 0);
    check("rst_clk", 32'(pad_clk), 0);
    check("rst_keys", 32'(keystates), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(st), 32'(IDLE));

    reset = 1'b0;
    @(negedge clk);
    wait_latch(waited);
    check("first_latch_wait", waited, 0);
    start = cyc;
    measure_frame(1, -1, 8'h00);
    prev = start;

    for (int i = 2; i <= 4; i++) begin
      buttons = 8'($urandom_range(0, 255));
      next_frame(i, prev, -1, 8'h00, start);
      prev = start;
    end

    // Start pressed after its bit has been sampled (bit 4 is sampled at t=31).
    buttons = 8'h00;
    next_frame(5, prev, 40, 8'h10, start);
    prev = start;
    next_frame(6, prev, -1, 8'h00, start);
    prev = start;

    mode = 1;
    next_frame(7, prev, -1, 8'h00, start);
    prev = start;
    mode = 2;
    next_frame(8, prev, -1, 8'h00, start);
    prev = start;

    // Reset during the third clock-high phase (t=24..27).
    mode = 0;
    buttons = 8'($urandom_range(1, 255));
    wait_latch(waited);
    check("f9_period", cyc - prev, POLL_CYC);
    repeat (25) @(negedge clk);
    check("abort_pre_clk", 32'(pad_clk), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_latch", 32'(pad_latch), 0);
    check("abort_clk", 32'(pad_clk), 0);
    check("abort_keys", 32'(keystates), 0);
    check("abort_valid", 32'(valid), 0);
    check("abort_busy", 32'(busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check("restart_latch", 32'(pad_latch), 1);
    buttons = 8'($urandom_range(0, 255));
    measure_frame(10, -1, 8'h00);

    // Back-to-back frames on the fast instance.
    n = 0;
    while (busy_f !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    n = 0;
    while (busy_f !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    check("fast_valid_in_idle", 32'(valid_f), 1);
    idle = 0;
    while (busy_f === 1'b0 && idle < 50) begin @(negedge clk); idle++; end
    check("fast_idle_len", idle, 1);
    check("fast_latch_next", 32'(pad_latch_f), 1);
    c0 = cyc;
    n = 0;
    while (pad_latch_f === 1'b1 && n < 200) begin @(negedge clk); n++; end
    while (pad_latch_f !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("fast_period", cyc - c0, FRAME_LEN + 1);
    check("fast_keys", 32'(keystates_f), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
